// File: rtl/mem_lsu32_if.sv
// Core-side request/response and memory-side read/write port bundle for mem_lsu32.
// slave is the LSU's view; master is the core/memory environment's view.
interface mem_lsu32_if;
  logic        in_req_valid;
  logic        out_req_ready;
  logic        in_req_write;
  logic [1:0]  in_req_size;
  logic        in_req_unsigned;
  logic [31:0] in_req_address;
  logic [31:0] in_req_data;
  logic        out_resp_valid;
  logic        in_resp_ready;
  logic [31:0] out_resp_data;
  logic        out_resp_exception;
  logic [31:0] out_read_address;
  logic [31:0] in_read_data;
  logic        in_read_exception;
  logic        out_write_enable;
  logic [31:0] out_write_address;
  logic [31:0] out_write_data;
  logic        in_write_exception;

  modport slave (
    input  in_req_valid, in_req_write, in_req_size, in_req_unsigned,
           in_req_address, in_req_data, in_resp_ready,
           in_read_data, in_read_exception, in_write_exception,
    output out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
           out_read_address, out_write_enable, out_write_address, out_write_data
  );

  modport master (
    output in_req_valid, in_req_write, in_req_size, in_req_unsigned,
           in_req_address, in_req_data, in_resp_ready,
           in_read_data, in_read_exception, in_write_exception,
    input  out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
           out_read_address, out_write_enable, out_write_address, out_write_data
  );
endinterface

// File: rtl/mem_lsu32.sv
// Load/store unit: word-aligned memory accesses, load lane extract/extend,
// sub-word stores as read-modify-write of the containing word.
//
// state | meaning
// IDLE  | ready for a request
// READ  | containing word on the read port, captured at end of cycle
// WRITE | single write strobe with the merged word
// RESP  | response held until the core takes it
module mem_lsu32 #(
  parameter bit          MISALIGN_CHECK     = 1'b1,
  parameter logic [31:0] RESP_DATA_ON_STORE = 32'h0
) (
  input logic          CLK,
  input logic          RESET,
  mem_lsu32_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_exc_q, resp_exc_d;
  logic [31:0] read_addr_q, read_addr_d;
  logic [31:0] write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;

  logic        accept;
  logic        req_exc;
  logic [1:0]  req_lane;
  logic [4:0]  shamt;
  logic [31:0] rd_shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && bus.in_req_valid;

  always_comb begin
    req_exc = 1'b0;
    if (bus.in_req_size == 2'd3) begin
      req_exc = 1'b1;
    end else if (MISALIGN_CHECK) begin
      req_exc = ((bus.in_req_size == 2'd1) && bus.in_req_address[0]) ||
                ((bus.in_req_size == 2'd2) && (bus.in_req_address[1:0] != 2'b00));
    end
  end

  // Without the misalign check the low bits are forced to natural alignment.
  always_comb begin
    req_lane = bus.in_req_address[1:0];
    if (bus.in_req_size == 2'd1) req_lane[0] = 1'b0;
    if (bus.in_req_size == 2'd2) req_lane    = 2'b00;
  end

  assign shamt      = {lane_q, 3'b000};
  assign rd_shifted = bus.in_read_data >> shamt;

  always_comb begin
    load_val  = bus.in_read_data;
    lane_mask = 32'hFFFF_FFFF;
    merged    = {16'h0, sdata_q};
    if (size_q == 2'd0) begin
      load_val  = uns_q ? {24'h0, rd_shifted[7:0]} : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      lane_mask = 32'h0000_00FF << shamt;
      merged    = (bus.in_read_data & ~lane_mask) | ({24'h0, sdata_q[7:0]} << shamt);
    end else if (size_q == 2'd1) begin
      load_val  = uns_q ? {16'h0, rd_shifted[15:0]} : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      lane_mask = 32'h0000_FFFF << shamt;
      merged    = (bus.in_read_data & ~lane_mask) | ({16'h0, sdata_q} << shamt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_exc)                                            state_d = RESP;
          else if (bus.in_req_write && (bus.in_req_size == 2'd2)) state_d = WRITE;
          else                                                    state_d = READ;
        end
      end
      READ:    state_d = (bus.in_read_exception || !write_q) ? RESP : WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (bus.in_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    sdata_d      = sdata_q;
    resp_data_d  = resp_data_q;
    resp_exc_d   = resp_exc_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = bus.in_req_write;
          size_d  = bus.in_req_size;
          uns_d   = bus.in_req_unsigned;
          lane_d  = req_lane;
          sdata_d = bus.in_req_data[15:0];
          if (req_exc) begin
            resp_data_d = 32'h0;
            resp_exc_d  = 1'b1;
          end else begin
            read_addr_d = {bus.in_req_address[31:2], 2'b00};
            if (bus.in_req_write && (bus.in_req_size == 2'd2)) begin
              write_addr_d = {bus.in_req_address[31:2], 2'b00};
              write_data_d = bus.in_req_data;
            end
          end
        end
      end
      READ: begin
        if (bus.in_read_exception) begin
          resp_data_d = 32'h0;
          resp_exc_d  = 1'b1;
        end else if (!write_q) begin
          resp_data_d = load_val;
          resp_exc_d  = 1'b0;
        end else begin
          write_addr_d = read_addr_q;
          write_data_d = merged;
        end
      end
      WRITE: begin
        resp_data_d = RESP_DATA_ON_STORE;
        resp_exc_d  = bus.in_write_exception;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      lane_q       <= 2'd0;
      sdata_q      <= 16'h0;
      resp_data_q  <= 32'h0;
      resp_exc_q   <= 1'b0;
      read_addr_q  <= 32'h0;
      write_addr_q <= 32'h0;
      write_data_q <= 32'h0;
    end else begin
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      sdata_q      <= sdata_d;
      resp_data_q  <= resp_data_d;
      resp_exc_q   <= resp_exc_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // Strobe and ready are gated by RESET so a reset mid-WRITE never commits.
  always_comb begin
    bus.out_req_ready      = (state_q == IDLE) && RESET;
    bus.out_resp_valid     = (state_q == RESP);
    bus.out_write_enable   = (state_q == WRITE) && RESET;
    bus.out_resp_data      = resp_data_q;
    bus.out_resp_exception = resp_exc_q;
    bus.out_read_address   = read_addr_q;
    bus.out_write_address  = write_addr_q;
    bus.out_write_data     = write_data_q;
  end

endmodule

// File: tb/tb_mem_lsu32.sv
// Directed plus randomized bench for mem_lsu32 against a byte-addressed
// memory model and a word-port memory environment.
module tb_mem_lsu32;
  logic CLK = 1'b0;
  logic RESET = 1'b0;

  mem_lsu32_if bus();
  mem_lsu32 dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:15];
  logic [7:0]  refb [0:63];
  logic [31:0] rd_fault = 32'h0000_0200;
  logic [31:0] wr_fault = 32'h0000_0204;
  int          wcnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  int          nvec = 0, nerr = 0;

  // Memory port: read data/faults settle mid-cycle from the registered addresses.
  always @(negedge CLK) begin
    bus.in_read_data       = mem[bus.out_read_address[5:2]];
    bus.in_read_exception  = (bus.out_read_address == rd_fault);
    bus.in_write_exception = (bus.out_write_address == wr_fault);
  end

  always @(posedge CLK) begin
    if (bus.out_write_enable === 1'b1) begin
      wcnt++;
      last_wa = bus.out_write_address;
      last_wd = bus.out_write_data;
      if (bus.out_write_address != wr_fault) mem[bus.out_write_address[5:2]] = bus.out_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory semantics, independent of any state sequencing.
  task automatic ref_exec(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic exc, output logic [31:0] rdata, output int lat,
                          output int nw, output logic [31:0] wa, output logic [31:0] wd);
    int nb, base, off;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[5:0]) & ~3;
    off  = int'(a[1:0]);
    exc = 1'b0; rdata = '0; nw = 0; wd = '0; lat = 2;
    wa  = {a[31:2], 2'b00};
    if (sz == 2'd3 || (off % nb) != 0) begin
      exc = 1'b1; lat = 1; return;
    end
    if (!(w && nb == 4) && wa == rd_fault) begin
      exc = 1'b1; lat = 2; return;
    end
    if (!w) begin
      for (int i = 0; i < nb; i++) rdata[8*i +: 8] = refb[base + off + i];
      if (!uns && nb < 4 && rdata[8*nb-1])
        for (int i = nb; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      return;
    end
    lat = (nb == 4) ? 2 : 3;
    nw  = 1;
    exc = (wa == wr_fault);
    for (int j = 0; j < 4; j++)
      wd[8*j +: 8] = (j >= off && j < off + nb) ? d[8*(j-off) +: 8] : refb[base + j];
    if (!exc) for (int j = 0; j < 4; j++) refb[base + j] = wd[8*j +: 8];
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input int hold);
    logic e_exc; logic [31:0] e_data, e_wa, e_wd; int e_lat, e_nw, w0, n;
    logic [31:0] held_data; logic held_exc;
    ref_exec(w, sz, uns, a, d, e_exc, e_data, e_lat, e_nw, e_wa, e_wd);
    w0 = wcnt;
    bus.in_req_valid = 1'b1; bus.in_req_write = w; bus.in_req_size = sz;
    bus.in_req_unsigned = uns; bus.in_req_address = a; bus.in_req_data = d;
    chk("req_ready", 32'(bus.out_req_ready), 32'd1);
    @(posedge CLK); #1;
    bus.in_req_valid = 1'b0;
    bus.in_req_write = 1'($urandom); bus.in_req_size = 2'($urandom);
    bus.in_req_unsigned = 1'($urandom); bus.in_req_address = $urandom; bus.in_req_data = $urandom;
    n = 1;
    while (bus.out_resp_valid !== 1'b1 && n < 8) begin @(posedge CLK); #1; n++; end
    chk("latency", 32'(n), 32'(e_lat));
    chk("resp_exc", 32'(bus.out_resp_exception), 32'(e_exc));
    chk("resp_data", bus.out_resp_data, e_data);
    held_data = bus.out_resp_data; held_exc = bus.out_resp_exception;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("hold_valid", 32'(bus.out_resp_valid), 32'd1);
      chk("hold_data", bus.out_resp_data, held_data);
      chk("hold_exc", 32'(bus.out_resp_exception), 32'(held_exc));
      chk("hold_ready", 32'(bus.out_req_ready), 32'd0);
    end
    bus.in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    bus.in_resp_ready = 1'b0;
    chk("idle_ready", 32'(bus.out_req_ready), 32'd1);
    chk("idle_valid", 32'(bus.out_resp_valid), 32'd0);
    chk("write_count", 32'(wcnt - w0), 32'(e_nw));
    if (e_nw == 1) begin
      chk("write_addr", last_wa, e_wa);
      chk("write_data", last_wd, e_wd);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, 32'(bus.out_resp_valid), 32'd0);
    chk({tag, "_resp_data"}, bus.out_resp_data, 32'd0);
    chk({tag, "_resp_exc"}, 32'(bus.out_resp_exception), 32'd0);
    chk({tag, "_read_addr"}, bus.out_read_address, 32'd0);
    chk({tag, "_write_en"}, 32'(bus.out_write_enable), 32'd0);
    chk({tag, "_write_addr"}, bus.out_write_address, 32'd0);
    chk({tag, "_write_data"}, bus.out_write_data, 32'd0);
  endtask

  initial begin
    int w0;
    logic [31:0] a;
    bus.in_req_valid = 1'b0; bus.in_req_write = 1'b0; bus.in_req_size = 2'd0;
    bus.in_req_unsigned = 1'b0; bus.in_req_address = '0; bus.in_req_data = '0;
    bus.in_resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h8899_AABB;
    for (int i = 0; i < 64; i++) refb[i] = mem[i/4][8*(i%4) +: 8];

    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    chk("reset_req_ready", 32'(bus.out_req_ready), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 0);  // 0xFFFFFFAA
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 0);  // 0x00008899
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_005A, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'h1234_5678, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'hBEEF, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0, 5);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_00EE, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0204, 32'hDEAD_0001, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0206, 32'h0000_7777, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0000_8001, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);

    // Reset while a sub-word store sits in READ: no strobe, clean outputs.
    w0 = wcnt;
    bus.in_req_valid = 1'b1; bus.in_req_write = 1'b1; bus.in_req_size = 2'd0;
    bus.in_req_unsigned = 1'b0; bus.in_req_address = 32'h0000_0102; bus.in_req_data = 32'h77;
    @(posedge CLK); #1;
    bus.in_req_valid = 1'b0;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk_all_zero("midreset");
    chk("midreset_req_ready", 32'(bus.out_req_ready), 32'd0);
    @(posedge CLK); #1;
    chk("midreset_writes", 32'(wcnt - w0), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("post_reset_ready", 32'(bus.out_req_ready), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0);

    for (int k = 0; k < 250; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : 32'h0000_0100;
      a = a | 32'($urandom_range(0, 63));
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
